// File: rtl/ncr5380_hba_if.sv
// ncr5380_hba_if: host-side bus of the NCR 5380 adapter.
// Register strobes, DMA handshake, read data and interrupt.
interface ncr5380_hba_if;
  logic       bus_cs;
  logic       ior;
  logic       iow;
  logic       dack;
  logic       eop;
  logic [2:0] bus_rs;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       dreq;
  logic       irq;

  modport master (
    output bus_cs, ior, iow, dack, eop,
    output bus_rs, wdata,
    input  rdata, dreq, irq
  );

  modport slave (
    input  bus_cs, ior, iow, dack, eop,
    input  bus_rs, wdata,
    output rdata, dreq, irq
  );
endinterface

// File: rtl/ncr5380_hba.sv
// ncr5380_hba: NCR 5380-compatible SCSI host adapter front end.
// Define NCR5380_IRQ_EN to build the interrupt logic.
module ncr5380_hba #(
  parameter int DEVS         = 2,
  parameter int HOST_ID      = 7,
  parameter int BUS_FREE_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  ncr5380_hba_if.slave      hb,
  output logic              scsi_sel,
  output logic              scsi_atn,
  output logic              scsi_ack,
  output logic              scsi_rst,
  output logic [7:0]        scsi_dout,
  input  logic [DEVS-1:0]   tgt_bsy,
  input  logic [DEVS-1:0]   tgt_req,
  input  logic [DEVS-1:0]   tgt_cd,
  input  logic [DEVS-1:0]   tgt_io,
  input  logic [DEVS-1:0]   tgt_msg,
  input  logic [8*DEVS-1:0] tgt_dout
);
  localparam int CW = $clog2(BUS_FREE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ARB
  } arb_t;

  logic          dma_any;
  logic [3:0]    raw, s1, s2, rise;
  logic          e1;
  logic [2:0]    rs1, rs_q;
  logic [7:0]    wd1, wd_q;
  logic          reg_wr, dma_wr, reg_rd;
  logic          dma_ack;
  logic          fall, dma_end;
  logic          eop_seen, eodma_set, rd7;
  logic [7:0]    dout, icr, mr, ser;
  logic [3:0]    tcr;
  logic          dma_en, dma_dir, eodma;
  arb_t          st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          mr0_q, la, aip, free;
  logic          t_req, t_cd, t_io, t_msg;
  logic [7:0]    t_dat;
  logic          pmatch, bsy, mism;
  logic          irq_bit;
  logic [7:0]    cur, icr_rd, csr, bsr, rd;
  logic          unused;

  // bit 0 reg write, 1 dma write, 2 reg read, 3 any dma
  assign dma_any = hb.bus_cs & hb.dack
                 & (hb.ior | hb.iow);
  assign raw = {
    dma_any,
    hb.bus_cs & ~hb.dack & hb.ior,
    hb.bus_cs & hb.dack & hb.iow,
    hb.bus_cs & ~hb.dack & hb.iow
  };
  assign rise      = s1 & ~s2;
  assign fall      = s2[3] & ~s1[3];
  assign dma_end   = fall & dma_en;
  assign eodma_set = dma_end & eop_seen;
  assign rd7       = reg_rd & (rs_q == 3'd7);

  // Sample host strobes and latch address/data on a new access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      e1     <= 1'b0;
      rs1    <= '0;
      wd1    <= '0;
      rs_q   <= '0;
      wd_q   <= '0;
      reg_wr <= 1'b0;
      dma_wr <= 1'b0;
      reg_rd <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      e1     <= hb.eop & dma_any;
      rs1    <= hb.bus_rs;
      wd1    <= hb.wdata;
      if (|rise[2:0]) begin
        rs_q <= rs1;
        wd_q <= wd1;
      end
      reg_wr <= rise[0];
      dma_wr <= rise[1];
      reg_rd <= rise[2];
    end
  end

  // Host-writable registers and DMA-out data path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      icr  <= '0;
      mr   <= '0;
      tcr  <= '0;
      ser  <= '0;
    end else begin
      if (reg_wr) begin
        case (rs_q)
          3'd0:    dout <= wd_q;
          3'd1:    icr  <= wd_q;
          3'd2:    mr   <= wd_q;
          3'd3:    tcr  <= wd_q[3:0];
          3'd4:    ser  <= wd_q;
          default: ;
        endcase
      end
      if (dma_wr && !dma_dir)
        dout <= wd_q;
    end
  end

  // DMA enable/direction, EOP tracking and ACK pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_en   <= 1'b0;
      dma_dir  <= 1'b0;
      eodma    <= 1'b0;
      eop_seen <= 1'b0;
      dma_ack  <= 1'b0;
    end else begin
      dma_ack <= dma_end;
      if (fall)
        eop_seen <= 1'b0;
      else if (e1)
        eop_seen <= 1'b1;
      if (!mr[1]) begin
        dma_en <= 1'b0;
        eodma  <= 1'b0;
      end else begin
        if (eodma_set) begin
          eodma  <= 1'b1;
          dma_en <= 1'b0;
        end else if (rd7) begin
          eodma  <= 1'b0;
        end
        if (reg_wr && rs_q == 3'd5) begin
          dma_en  <= 1'b1;
          dma_dir <= 1'b0;
        end else if (reg_wr && rs_q == 3'd7) begin
          dma_en  <= 1'b1;
          dma_dir <= 1'b1;
        end
      end
    end
  end

  // Highest-index busy target owns the phase and data lines.
  always_comb begin
    t_req = 1'b0;
    t_cd  = 1'b0;
    t_io  = 1'b0;
    t_msg = 1'b0;
    t_dat = 8'h55;
    for (int i = 0; i < DEVS; i++) begin
      if (tgt_bsy[i]) begin
        t_req = tgt_req[i];
        t_cd  = tgt_cd[i];
        t_io  = tgt_io[i];
        t_msg = tgt_msg[i];
        t_dat = tgt_dout[8*i +: 8];
      end
    end
  end

  assign free = ~(|tgt_bsy) & ~icr[2];
  assign aip  = (st == ARB);

  // Arbitration state, bus-free counter and lost-arbitration flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      cnt   <= '0;
      mr0_q <= 1'b0;
      la    <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      mr0_q <= mr[0];
      if (st == IDLE)
        la <= 1'b0;
      else if (st == ARB && scsi_sel && !icr[3])
        la <= 1'b1;
    end
  end

  // Arbitration next state: wait for a quiet bus, then hold AIP.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (mr[0] && !mr0_q)
          st_n = WAIT;
      end
      WAIT: begin
        if (!mr[0])
          st_n = IDLE;
        else if (!free)
          cnt_n = '0;
        else if (cnt == CW'(BUS_FREE_CYC - 1))
          st_n = ARB;
        else
          cnt_n = cnt + CW'(1);
      end
      ARB: begin
        if (!mr[0])
          st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign pmatch  = (tcr[2:0] == {t_msg, t_cd, t_io});
  assign mism    = dma_en & t_req & ~pmatch;
  assign bsy     = icr[3] | aip | (|tgt_bsy);
  assign hb.dreq = dma_en & t_req & pmatch;

`ifdef NCR5380_IRQ_EN
  logic irq_q, rst_q;

  // Interrupt: any source sets, register 7 read clears, set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
      rst_q <= 1'b0;
    end else begin
      rst_q <= icr[7];
      if (eodma_set || mism || (icr[7] && !rst_q))
        irq_q <= 1'b1;
      else if (rd7)
        irq_q <= 1'b0;
    end
  end

  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign hb.irq    = irq_bit;
  assign scsi_sel  = icr[2];
  assign scsi_atn  = icr[1];
  assign scsi_rst  = icr[7];
  assign scsi_ack  = icr[4] | dma_ack;
  assign scsi_dout = aip ? 8'(1 << HOST_ID) : dout;

  assign cur    = (icr[0] | aip) ? dout : t_dat;
  assign icr_rd = {icr[7], aip, la, icr[4:0]};
  assign csr    = {icr[7], bsy, t_req, t_msg,
                   t_cd, t_io, icr[2], 1'b0};
  assign bsr    = {eodma, hb.dreq, 1'b0, irq_bit,
                   pmatch, 1'b0, icr[1], scsi_ack};

  // Combinational host read mux.
  always_comb begin
    rd = 8'hFF;
    if (hb.dack) begin
      rd = cur;
    end else begin
      case (hb.bus_rs)
        3'd0:    rd = cur;
        3'd1:    rd = icr_rd;
        3'd2:    rd = mr;
        3'd3:    rd = {4'h0, tcr};
        3'd4:    rd = csr;
        3'd5:    rd = bsr;
        3'd6:    rd = cur;
        default: rd = 8'hFF;
      endcase
    end
  end

  assign hb.rdata = rd;
  assign unused   = ^{ser, icr[6:5]};
endmodule

// File: tb/tb_ncr5380_hba.sv
// tb_ncr5380_hba: table-driven register reads plus
// hand-written arbitration, DMA and interrupt sequences.
module tb_ncr5380_hba;
`ifdef NCR5380_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        scsi_sel, scsi_atn, scsi_ack, scsi_rst;
  logic [7:0]  scsi_dout;
  logic [1:0]  tgt_bsy, tgt_req, tgt_cd, tgt_io, tgt_msg;
  logic [15:0] tgt_dout;
  int          ack_cnt = 0;

  always #5 clk = ~clk;

  ncr5380_hba_if hb();

  ncr5380_hba #(
    .DEVS(2),
    .HOST_ID(7),
    .BUS_FREE_CYC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hb(hb),
    .scsi_sel(scsi_sel),
    .scsi_atn(scsi_atn),
    .scsi_ack(scsi_ack),
    .scsi_rst(scsi_rst),
    .scsi_dout(scsi_dout),
    .tgt_bsy(tgt_bsy),
    .tgt_req(tgt_req),
    .tgt_cd(tgt_cd),
    .tgt_io(tgt_io),
    .tgt_msg(tgt_msg),
    .tgt_dout(tgt_dout)
  );

  always @(negedge clk)
    if (scsi_ack) ack_cnt <= ack_cnt + 1;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic [1:0] bsy;
    logic [1:0] req;
    logic [1:0] io;
    logic       dack;
    logic [2:0] rs;
    logic [7:0] exp;
    string      name;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[14];
  int   passed = 0;
  int   total = 0;

  function automatic vec_t mk(
    logic [1:0] b, logic [1:0] r, logic [1:0] i,
    logic d, logic [2:0] rs, logic [7:0] e, string n);
    vec_t v;
    v.bsy = b; v.req = r; v.io = i; v.dack = d;
    v.rs = rs; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic expect_val(string n, logic [7:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic observe(logic [7:0] got);
    sb_t s;
    total++;
    if (sbq.size() == 0) begin
      $display("FAIL scoreboard: got %h with nothing expected",
               got);
      return;
    end
    s = sbq.pop_front();
    if (got === s.exp)
      passed++;
    else
      $display("FAIL %s: got %h, want %h",
               s.name, got, s.exp);
  endtask

  task automatic chk(string n, logic [7:0] got,
                     logic [7:0] e);
    expect_val(n, e);
    observe(got);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Short read between clock edges: no strobe is sampled.
  task automatic peek(logic [2:0] rs, logic d,
                      output logic [7:0] v);
    hb.bus_rs = rs;
    hb.dack   = d;
    hb.bus_cs = 1'b1;
    hb.ior    = 1'b1;
    #1 v = hb.rdata;
    #1;
    hb.bus_cs = 1'b0;
    hb.ior    = 1'b0;
    hb.dack   = 1'b0;
  endtask

  task automatic reg_write(logic [2:0] rs, logic [7:0] d);
    @(negedge clk);
    hb.bus_rs = rs;
    hb.wdata  = d;
    hb.bus_cs = 1'b1;
    hb.iow    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hb.bus_cs = 1'b0;
    hb.iow    = 1'b0;
  endtask

  task automatic rd_pulse(logic [2:0] rs,
                          output logic [7:0] v);
    @(negedge clk);
    hb.bus_rs = rs;
    hb.bus_cs = 1'b1;
    hb.ior    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = hb.rdata;
    hb.bus_cs = 1'b0;
    hb.ior    = 1'b0;
    tick(3);
  endtask

  task automatic dma_acc(logic wr, logic e, logic [7:0] d,
                         output logic [7:0] v);
    @(negedge clk);
    hb.wdata  = d;
    hb.eop    = e;
    hb.dack   = 1'b1;
    hb.bus_cs = 1'b1;
    hb.ior    = ~wr;
    hb.iow    = wr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = hb.rdata;
    hb.bus_cs = 1'b0;
    hb.ior    = 1'b0;
    hb.iow    = 1'b0;
    hb.dack   = 1'b0;
    hb.eop    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int a0;

    reset = 1'b1;
    hb.bus_cs = 0; hb.ior = 0; hb.iow = 0;
    hb.dack = 0; hb.eop = 0;
    hb.bus_rs = 0; hb.wdata = 0;
    tgt_bsy = 0; tgt_req = 0; tgt_cd = 0;
    tgt_io = 0; tgt_msg = 0;
    tgt_dout = {8'hA5, 8'h3C};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    chk("reset_scsi",
        {2'b0, scsi_sel, scsi_atn, scsi_ack,
         scsi_rst, hb.dreq, hb.irq}, 8'h00);
    chk("reset_dout", scsi_dout, 8'h00);

    tbl[0]  = mk(2'b00, 2'b00, 2'b00, 0, 4, 8'h00, "csr_reset");
    tbl[1]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 8'h55, "cdr_idle");
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 0, 6, 8'h55, "idr_idle");
    tbl[3]  = mk(2'b00, 2'b00, 2'b00, 0, 5, 8'h08, "bsr_reset");
    tbl[4]  = mk(2'b00, 2'b00, 2'b00, 0, 1, 8'h00, "icr_reset");
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 0, 2, 8'h00, "mr_reset");
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 0, 3, 8'h00, "tcr_reset");
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 0, 7, 8'hFF, "reg7");
    tbl[8]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 8'hA5, "prio_both");
    tbl[9]  = mk(2'b01, 2'b00, 2'b00, 0, 0, 8'h3C, "prio_t0");
    tbl[10] = mk(2'b01, 2'b01, 2'b01, 0, 4, 8'h64, "csr_t0");
    tbl[11] = mk(2'b10, 2'b01, 2'b10, 0, 4, 8'h44, "csr_t1");
    tbl[12] = mk(2'b11, 2'b00, 2'b00, 1, 4, 8'hA5, "dack_cur");
    tbl[13] = mk(2'b01, 2'b01, 2'b01, 0, 5, 8'h00, "bsr_nomatch");

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      tgt_bsy = tbl[i].bsy;
      tgt_req = tbl[i].req;
      tgt_io  = tbl[i].io;
      expect_val(tbl[i].name, tbl[i].exp);
      peek(tbl[i].rs, tbl[i].dack, v);
      observe(v);
    end
    @(negedge clk);
    tgt_bsy = 0; tgt_req = 0; tgt_io = 0;

    reg_write(0, 8'h5A);
    chk("odr_dout", scsi_dout, 8'h5A);

    // arbitration on a free bus
    reg_write(2, 8'h01);
    tick(8);
    peek(1, 0, v);
    chk("aip_early", v, 8'h00);
    tick(1);
    peek(1, 0, v);
    chk("aip_on_time", v, 8'h40);
    chk("arb_dout", scsi_dout, 8'h80);
    peek(0, 0, v);
    chk("cdr_aip", v, 8'h5A);
    reg_write(1, 8'h04);
    tick(1);
    peek(1, 0, v);
    chk("la_set", v, 8'h64);
    reg_write(2, 8'h00);
    tick(2);
    peek(1, 0, v);
    chk("arb_idle", v, 8'h04);
    reg_write(1, 8'h00);

    // busy target delays arbitration
    tgt_bsy = 2'b01;
    reg_write(2, 8'h01);
    tick(6);
    tgt_bsy = 2'b00;
    tick(7);
    peek(1, 0, v);
    chk("busy_aip_early", v, 8'h00);
    tick(1);
    peek(1, 0, v);
    chk("busy_aip_on", v, 8'h40);
    reg_write(2, 8'h00);
    tick(2);

    // DMA in with EOP
    reg_write(2, 8'h02);
    reg_write(3, 8'h01);
    tgt_bsy = 2'b01; tgt_req = 2'b01; tgt_io = 2'b01;
    reg_write(7, 8'h00);
    chk("dreq_on", {7'b0, hb.dreq}, 8'h01);
    peek(5, 0, v);
    chk("bsr_dma", v, 8'h48);
    a0 = ack_cnt;
    dma_acc(1'b1, 1'b0, 8'h77, v);
    tick(4);
    chk("dir_in_ignored", scsi_dout, 8'h5A);
    dma_acc(1'b0, 1'b1, 8'h00, v);
    chk("dma_rd_data", v, 8'h3C);
    tick(1);
    chk("ack_early", {7'b0, scsi_ack}, 8'h00);
    tick(1);
    chk("ack_pulse", {7'b0, scsi_ack}, 8'h01);
    peek(5, 0, v);
    chk("bsr_eodma", v, {3'b100, IRQ_ON, 4'b1001});
    chk("irq_eodma", {7'b0, hb.irq}, {7'b0, IRQ_ON});
    tick(1);
    chk("ack_end", {7'b0, scsi_ack}, 8'h00);
    tick(2);
    chk("ack_count", 8'(ack_cnt - a0), 8'h02);
    rd_pulse(7, v);
    chk("reg7_pulse", v, 8'hFF);
    chk("irq_clr", {7'b0, hb.irq}, 8'h00);
    peek(5, 0, v);
    chk("bsr_clr", v, 8'h08);

    // phase mismatch
    reg_write(3, 8'h00);
    reg_write(7, 8'h00);
    tick(1);
    chk("mm_dreq", {7'b0, hb.dreq}, 8'h00);
    peek(5, 0, v);
    chk("mm_bsr", v, {3'b000, IRQ_ON, 4'b0000});
    chk("mm_irq", {7'b0, hb.irq}, {7'b0, IRQ_ON});
    rd_pulse(7, v);
    chk("set_wins", {7'b0, hb.irq}, {7'b0, IRQ_ON});
    reg_write(2, 8'h00);
    rd_pulse(7, v);
    chk("mm_irq_clr", {7'b0, hb.irq}, 8'h00);

    // bus reset interrupt
    reg_write(1, 8'h80);
    tick(1);
    chk("rst_out", {7'b0, scsi_rst}, 8'h01);
    chk("rst_irq", {7'b0, hb.irq}, {7'b0, IRQ_ON});
    peek(1, 0, v);
    chk("rst_icr", v, 8'h80);
    reg_write(1, 8'h00);
    rd_pulse(7, v);
    chk("rst_irq_clr", {7'b0, hb.irq}, 8'h00);

    // reset in the middle of a DMA access
    reg_write(2, 8'h02);
    reg_write(3, 8'h01);
    reg_write(7, 8'h00);
    chk("g_dreq", {7'b0, hb.dreq}, 8'h01);
    a0 = ack_cnt;
    @(negedge clk);
    hb.dack = 1'b1; hb.bus_cs = 1'b1; hb.ior = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("g_dreq_drop", {7'b0, hb.dreq}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    hb.dack = 1'b0; hb.bus_cs = 1'b0; hb.ior = 1'b0;
    tick(4);
    chk("g_no_ack", 8'(ack_cnt - a0), 8'h00);
    chk("g_dreq_off", {7'b0, hb.dreq}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
